// File: rtl/lc3b_pipe_stage_pkg.sv
// rtl/lc3b_pipe_stage_pkg.sv - shared LC-3b pipeline payload layout, defaults and stage state encoding
package lc3b_pipe_stage_pkg;

    // One beat between stages: control word, register specifiers, data words.
    typedef struct packed {
        logic [22:0] ctrl;
        logic [2:0]  dr;
        logic [2:0]  sr1;
        logic [2:0]  sr2;
        logic [15:0] pc;
        logic [15:0] ir;
        logic [15:0] sr1_val;
        logic [15:0] sr2_val;
        logic [15:0] alu_out;
        logic [15:0] mem_addr;
        logic [15:0] mdr;
    } lc3b_pipe_payload;

    localparam int LC3B_PIPE_WIDTH        = $bits(lc3b_pipe_payload);
    localparam int LC3B_PIPE_SKID_DEFAULT = 1;

    // Bit 0 is the main (out) valid, bit 1 the skid valid, so both are
    // read straight off the state flops.
    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'b00,
        PIPE_ONE   = 2'b01,
        PIPE_FULL  = 2'b11
    } pipe_state_t;

endpackage

// File: rtl/lc3b_pipe_stage_register.sv
// rtl/lc3b_pipe_stage_register.sv - load-enabled data register with synchronous clear
// Ports: clk, reset (sync, active-high, clears q), load (capture d), d, q.
module lc3b_pipe_stage_register #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/lc3b_pipe_stage.sv
// rtl/lc3b_pipe_stage.sv - valid/ready inter-stage pipeline register with optional skid entry and flush
// Ports: clk, reset (sync, active-high); upstream in_valid/in_ready/in_data;
//        flush squashes held beats; downstream out_valid/out_ready/out_data;
//        stall_cnt/bubble_cnt/flush_cnt saturating counters exist only when
//        LC3B_PIPE_PERF_EN is defined.
module lc3b_pipe_stage
    import lc3b_pipe_stage_pkg::*;
#(
    parameter int WIDTH     = LC3B_PIPE_WIDTH,
    parameter int SKID      = LC3B_PIPE_SKID_DEFAULT,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data
`ifdef LC3B_PIPE_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] bubble_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
`endif
);

    if (WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_param
        $error("lc3b_pipe_stage: WIDTH and CNT_WIDTH must be >= 1");
    end

    pipe_state_t      state_q, state_d;
    logic             skid_valid;
    logic             accept, consume;
    logic             main_load, skid_load, main_from_skid;
    logic [WIDTH-1:0] main_d, skid_data;

    assign out_valid  = state_q[0];
    assign skid_valid = state_q[1];
    assign accept     = in_valid & in_ready;
    assign consume    = out_valid & out_ready;

    // SKID=0 chains ready combinationally; SKID=1 breaks that path so in_ready
    // is a flop bit and the skid entry absorbs the beat already in flight.
    if (SKID != 0) begin : g_skid_ready
        assign in_ready = ~skid_valid;
    end else begin : g_single_ready
        assign in_ready = ~out_valid | out_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PIPE_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            PIPE_EMPTY: begin
                if (accept) begin
                    state_d   = PIPE_ONE;
                    main_load = 1'b1;
                end
            end
            PIPE_ONE: begin
                // Without a skid entry an accept while holding a beat implies consume.
                if (accept) begin
                    if (consume || SKID == 0) begin
                        main_load = 1'b1;
                    end else begin
                        state_d   = PIPE_FULL;
                        skid_load = 1'b1;
                    end
                end else if (consume) begin
                    state_d = PIPE_EMPTY;
                end
            end
            PIPE_FULL: begin
                // in_ready is low here, so the skid beat always goes out next.
                if (consume) begin
                    state_d        = PIPE_ONE;
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = PIPE_EMPTY;
        endcase
        // Data registers may still load during flush; the cleared valids make it moot.
        if (flush) begin
            state_d = PIPE_EMPTY;
        end
    end

    assign main_d = main_from_skid ? skid_data : in_data;

    lc3b_pipe_stage_register #(.width(WIDTH)) u_main_reg (
        .clk   (clk),
        .reset (reset),
        .load  (main_load),
        .d     (main_d),
        .q     (out_data)
    );

    lc3b_pipe_stage_register #(.width(WIDTH)) u_skid_reg (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .d     (in_data),
        .q     (skid_data)
    );

`ifdef LC3B_PIPE_PERF_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // A flush kills a beat unless that beat is leaving downstream this cycle;
    // a beat accepted in the flush cycle is killed as well.
    logic kill;
    assign kill = flush & ((out_valid & ~out_ready) | skid_valid | accept);

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (!out_valid && bubble_cnt != CNT_MAX) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
            if (kill && flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lc3b_pipe_stage.sv
// tb/tb_lc3b_pipe_stage.sv - directed self-checking bench for lc3b_pipe_stage, SKID=0 and SKID=1 instances
module tb_lc3b_pipe_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        a_in_valid = 1'b0, a_in_ready, a_flush = 1'b0, a_out_valid, a_out_ready = 1'b0;
    logic [15:0] a_in_data = '0, a_out_data;
    logic        b_in_valid = 1'b0, b_in_ready, b_flush = 1'b0, b_out_valid, b_out_ready = 1'b0;
    logic [15:0] b_in_data = '0, b_out_data;
`ifdef LC3B_PIPE_PERF_EN
    logic [3:0]  a_stall_cnt, a_bubble_cnt, a_flush_cnt;
    logic [3:0]  b_stall_cnt, b_bubble_cnt, b_flush_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lc3b_pipe_stage #(.WIDTH(16), .SKID(0), .CNT_WIDTH(4)) u_s0 (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (a_in_valid),
        .in_ready   (a_in_ready),
        .in_data    (a_in_data),
        .flush      (a_flush),
        .out_valid  (a_out_valid),
        .out_ready  (a_out_ready),
        .out_data   (a_out_data)
`ifdef LC3B_PIPE_PERF_EN
        ,
        .stall_cnt  (a_stall_cnt),
        .bubble_cnt (a_bubble_cnt),
        .flush_cnt  (a_flush_cnt)
`endif
    );

    lc3b_pipe_stage #(.WIDTH(16), .SKID(1), .CNT_WIDTH(4)) u_s1 (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .in_data    (b_in_data),
        .flush      (b_flush),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .out_data   (b_out_data)
`ifdef LC3B_PIPE_PERF_EN
        ,
        .stall_cnt  (b_stall_cnt),
        .bubble_cnt (b_bubble_cnt),
        .flush_cnt  (b_flush_cnt)
`endif
    );

    // Directed tables for the SKID=0 toggling-ready run.
    logic [15:0] t3_din [6] = '{16'h0010, 16'h0011, 16'h0011, 16'h0012, 16'h0012, 16'h0013};
    logic        t3_or  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        t3_ir  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        t3_ov  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [15:0] t3_dout[6] = '{16'h0000, 16'h0010, 16'h0010, 16'h0011, 16'h0011, 16'h0012};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        // Reset
        tick();
        tick();
        reset = 1'b0;
        settle();
        check("rst_a_out_valid", a_out_valid, 0);
        check("rst_a_out_data",  a_out_data, 0);
        check("rst_a_in_ready",  a_in_ready, 1);
        check("rst_b_out_valid", b_out_valid, 0);
        check("rst_b_out_data",  b_out_data, 0);
        check("rst_b_in_ready",  b_in_ready, 1);

        // Test 1: single beat, 1-cycle latency, SKID=0
        a_in_valid = 1'b1; a_in_data = 16'h1234; a_out_ready = 1'b1;
        settle();
        check("t1_in_ready_c0", a_in_ready, 1);
        tick();
        a_in_valid = 1'b0;
        settle();
        check("t1_out_valid", a_out_valid, 1);
        check("t1_out_data",  a_out_data, 16'h1234);
        check("t1_in_ready_c1", a_in_ready, 1);
        tick();
        settle();
        check("t1_drained", a_out_valid, 0);

        // Test 3: SKID=0, out_ready toggling under continuous input
        for (int i = 0; i < 6; i++) begin
            a_in_valid = 1'b1; a_in_data = t3_din[i]; a_out_ready = t3_or[i];
            settle();
            check($sformatf("t3_in_ready_c%0d", i), a_in_ready, t3_ir[i]);
            check($sformatf("t3_out_valid_c%0d", i), a_out_valid, t3_ov[i]);
            if (t3_ov[i]) check($sformatf("t3_out_data_c%0d", i), a_out_data, t3_dout[i]);
            tick();
        end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        settle();
        check("t3_last_valid", a_out_valid, 1);
        check("t3_last_data",  a_out_data, 16'h0012);
        tick();
        settle();
        check("t3_empty", a_out_valid, 0);

        // SKID=0 flush with out_ready: held beat leaves, accepted beat is discarded
        a_in_valid = 1'b1; a_in_data = 16'h0020; a_out_ready = 1'b0;
        tick();
        a_in_data = 16'h0021; a_out_ready = 1'b1; a_flush = 1'b1;
        settle();
        check("fl0_out_data", a_out_data, 16'h0020);
        check("fl0_in_ready", a_in_ready, 1);
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0;
        settle();
        check("fl0_valid_after", a_out_valid, 0);
        check("fl0_ready_after", a_in_ready, 1);
        tick();
        settle();
        check("fl0_no_ghost", a_out_valid, 0);

        // Test 2: SKID=1, A,B,C with out_ready low from cycle 1
        b_in_valid = 1'b1; b_in_data = 16'h000A; b_out_ready = 1'b1;
        settle();
        check("t2_c0_in_ready", b_in_ready, 1);
        tick();
        b_in_data = 16'h000B; b_out_ready = 1'b0;
        settle();
        check("t2_c1_out_data", b_out_data, 16'h000A);
        check("t2_c1_in_ready", b_in_ready, 1);
        tick();
        b_in_data = 16'h000C;
        settle();
        check("t2_full_valid", b_out_valid, 1);
        check("t2_full_data",  b_out_data, 16'h000A);
        check("t2_full_ready", b_in_ready, 0);
        tick();
        b_out_ready = 1'b1;
        settle();
        check("t2_out_A", b_out_data, 16'h000A);
        check("t2_c3_in_ready", b_in_ready, 0);
        tick();
        settle();
        check("t2_out_B", b_out_data, 16'h000B);
        check("t2_c4_in_ready", b_in_ready, 1);
        tick();
        b_in_valid = 1'b0;
        settle();
        check("t2_out_C", b_out_data, 16'h000C);
        check("t2_out_C_valid", b_out_valid, 1);
        tick();
        settle();
        check("t2_empty", b_out_valid, 0);

        // Test 4: FULL, flush with D presented
        b_in_valid = 1'b1; b_in_data = 16'h00A1; b_out_ready = 1'b0;
        tick();
        b_in_data = 16'h00B2;
        tick();
        b_in_data = 16'h00D0; b_flush = 1'b1;
        settle();
        check("t4_full_ready", b_in_ready, 0);
        tick();
        b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
        settle();
        check("t4_valid_after", b_out_valid, 0);
        check("t4_ready_after", b_in_ready, 1);
        tick();
        settle();
        check("t4_no_D", b_out_valid, 0);

        // Test 5: reset while FULL
        b_in_valid = 1'b1; b_in_data = 16'h00E1; b_out_ready = 1'b0;
        tick();
        b_in_data = 16'h00E2;
        tick();
        b_in_valid = 1'b0;
        settle();
        check("t5_full_ready", b_in_ready, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        check("t5_valid", b_out_valid, 0);
        check("t5_data",  b_out_data, 0);
        check("t5_ready", b_in_ready, 1);
        b_in_valid = 1'b1; b_in_data = 16'h00E5;
        tick();
        b_in_valid = 1'b0;
        settle();
        check("t5_resume_valid", b_out_valid, 1);
        check("t5_resume_data",  b_out_data, 16'h00E5);

`ifdef LC3B_PIPE_PERF_EN
        // Test 6: counters, CNT_WIDTH=4
        reset = 1'b1;
        tick();
        reset = 1'b0;
        b_in_valid = 1'b1; b_in_data = 16'h0066; b_out_ready = 1'b0;
        settle();
        check("t6_rst_stall", b_stall_cnt, 0);
        tick();
        b_in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        settle();
        check("t6_stall_sat", b_stall_cnt, 15);
        check("t6_bubble",    b_bubble_cnt, 1);
        check("t6_flush0",    b_flush_cnt, 0);
        b_flush = 1'b1;
        tick();
        b_flush = 1'b0;
        settle();
        check("t6_flush1", b_flush_cnt, 1);
        check("t6_flushed_valid", b_out_valid, 0);
        b_flush = 1'b1;
        tick();
        b_flush = 1'b0;
        settle();
        check("t6_flush_empty", b_flush_cnt, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
